// File: rtl/yadmc_sync_hs.sv
// rtl/yadmc_sync_hs.sv - multi-channel pulse-plus-payload synchroniser clk0 -> clk1
// Toggle-request handshake per channel with a one-deep pending slot and sticky overflow.
module yadmc_sync_hs #(
  parameter int NCH    = 4,
  parameter int DW     = 8,
  parameter int STAGES = 2
) (
  input  logic              clk0,
  input  logic              rst,
  input  logic              clk1,
  input  logic [NCH-1:0]    flagi,
  input  logic [NCH*DW-1:0] datai,
  input  logic              ovf_clr,
  output logic [NCH-1:0]    busy,
  output logic [NCH-1:0]    overflow,
  output logic [NCH-1:0]    flago,
  output logic [NCH*DW-1:0] datao
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              drop;
    logic              busy_w;
    logic              ack_arr;
    logic              req_edge;
    logic [DW-1:0]     din;
    logic [DW-1:0]     hold_q, hold_d;
    logic [DW-1:0]     pend_data_q, pend_data_d;
    logic [STAGES-1:0] ack_sync_q, ack_sync_d;
    logic [STAGES:0]   s_q, s_d;
    logic              flago_q, flago_d;
    logic [DW-1:0]     datao_q, datao_d;

    assign din     = datai[g*DW +: DW];
    assign ack_arr = (ack_sync_q[STAGES-1] == req_q);

    always_ff @(posedge clk0) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
    end

    always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      hold_d      = hold_q;
      pend_d      = pend_q;
      pend_data_d = pend_data_q;
      drop        = 1'b0;
      case (state_q)
        IDLE: begin
          if (flagi[g]) begin
            hold_d  = din;
            req_d   = ~req_q;
            state_d = WAIT;
          end
        end
        default: begin
          if (!ack_arr) begin
            if (flagi[g] && !pend_q) begin
              pend_d      = 1'b1;
              pend_data_d = din;
            end else if (flagi[g]) begin
              drop = 1'b1;
            end
          end else if (pend_q) begin
            // Ack frees the hold slot, so a coincident event refills pend instead of dropping.
            hold_d = pend_data_q;
            req_d  = ~req_q;
            pend_d = flagi[g];
            if (flagi[g]) pend_data_d = din;
          end else if (flagi[g]) begin
            hold_d = din;
            req_d  = ~req_q;
          end else begin
            state_d = IDLE;
          end
        end
      endcase
    end

    always_comb begin
      busy_w = (state_q == WAIT);
    end

    always_comb begin
      ovf_d = ovf_q;
      if (ovf_clr) ovf_d = 1'b0;
      if (drop)    ovf_d = 1'b1;
    end

    assign ack_sync_d = {ack_sync_q[STAGES-2:0], s_q[STAGES-1]};

    always_ff @(posedge clk0) begin
      if (rst) begin
        req_q       <= 1'b0;
        hold_q      <= '0;
        pend_q      <= 1'b0;
        pend_data_q <= '0;
        ovf_q       <= 1'b0;
        ack_sync_q  <= '0;
      end else begin
        req_q       <= req_d;
        hold_q      <= hold_d;
        pend_q      <= pend_d;
        pend_data_q <= pend_data_d;
        ovf_q       <= ovf_d;
        ack_sync_q  <= ack_sync_d;
      end
    end

    // hold_q is only sampled on a request edge, when it has been stable since the toggle.
    assign req_edge = s_q[STAGES-1] ^ s_q[STAGES];
    assign s_d      = {s_q[STAGES-1:0], req_q};

    always_comb begin
      flago_d = req_edge;
      datao_d = req_edge ? hold_q : datao_q;
    end

    always_ff @(posedge clk1) begin
      if (rst) begin
        s_q     <= '0;
        flago_q <= 1'b0;
        datao_q <= '0;
      end else begin
        s_q     <= s_d;
        flago_q <= flago_d;
        datao_q <= datao_d;
      end
    end

    assign busy[g]            = busy_w;
    assign overflow[g]        = ovf_q;
    assign flago[g]           = flago_q;
    assign datao[g*DW +: DW]  = datao_q;
  end

endmodule

// File: tb/tb_yadmc_sync_hs.sv
// tb/tb_yadmc_sync_hs.sv - self-checking bench for yadmc_sync_hs
// Directed handshake timing plus randomized cross-ratio traffic against a per-channel payload queue.
`timescale 1ns/1ps
module tb_yadmc_sync_hs;
  localparam int NCH = 4;
  localparam int DW  = 8;

  logic              clk0 = 1'b0;
  logic              clk1 = 1'b0;
  logic              rst = 1'b1;
  logic              ovf_clr = 1'b0;
  logic [NCH-1:0]    flagi = '0;
  logic [NCH*DW-1:0] datai = '0;
  logic [NCH-1:0]    busy, overflow, flago;
  logic [NCH*DW-1:0] datao;

  int h0 = 5;
  int h1 = 5;
  always #(h0) clk0 = ~clk0;
  always #(h1) clk1 = ~clk1;

  yadmc_sync_hs #(.NCH(NCH), .DW(DW), .STAGES(2)) dut (
    .clk0(clk0), .rst(rst), .clk1(clk1), .flagi(flagi), .datai(datai),
    .ovf_clr(ovf_clr), .busy(busy), .overflow(overflow), .flago(flago), .datao(datao)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [DW-1:0] expq[NCH][$];
  int dlv[NCH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Every regenerated event must match the oldest accepted payload of its channel.
  always @(negedge clk1) begin
    for (int i = 0; i < NCH; i++) begin
      if (flago[i] === 1'b1) begin
        dlv[i]++;
        if (expq[i].size() == 0) check($sformatf("dup_ch%0d", i), 32'd1, 32'd0);
        else check($sformatf("data_ch%0d", i), {24'd0, datao[i*DW +: DW]}, {24'd0, expq[i].pop_front()});
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk0);
      #1;
    end
  endtask

  task automatic fire(input int ch, input logic [DW-1:0] d, input bit acc);
    flagi[ch] = 1'b1;
    datai[ch*DW +: DW] = d;
    if (acc) expq[ch].push_back(d);
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NCH; i++) if (expq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain();
    for (int k = 0; k < 3000 && !all_empty(); k++) step();
    step(20);
    check("drain", {31'd0, all_empty()}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flagi = '0;
    ovf_clr = 1'b0;
    step(30);
    for (int i = 0; i < NCH; i++) begin
      expq[i].delete();
      dlv[i] = 0;
    end
    rst = 1'b0;
    step(2);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int total;
    int cyc;
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);
    check("rst_flago", flago, 0);
    check("rst_datao", datao, 0);

    // Equal clocks: single event latency and busy window.
    fire(0, 8'hA5, 1'b1);
    for (int k = 0; k <= 5; k++) begin
      step();
      flagi = '0;
      check($sformatf("lat_flago_e%0d", k), flago, (k == 3) ? 32'd1 : 32'd0);
      check($sformatf("lat_busy_e%0d", k), busy, (k < 5) ? 32'd1 : 32'd0);
      if (k == 3) check("lat_datao", datao[7:0], 8'hA5);
    end
    drain();

    // Three back-to-back events: third is dropped.
    fire(1, 8'h11, 1'b1); step();
    fire(1, 8'h22, 1'b1); step();
    fire(1, 8'h33, 1'b0); step();
    flagi = '0;
    drain();
    check("ovf1_set", overflow, 4'b0010);
    check("ovf1_dlv", dlv[1], 2);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    check("ovf1_clr", overflow, 0);

    // Pending full while ack arrives (e5): new event is queued, not dropped.
    fire(0, 8'h31, 1'b1); step(); flagi = '0;
    fire(0, 8'h32, 1'b1); step(); flagi = '0;
    step(3);
    fire(0, 8'h33, 1'b1); step(); flagi = '0;
    drain();
    check("coinc_ovf", overflow, 0);
    check("coinc_dlv", dlv[0], 4);

    // Overflow clear coincident with a drop on channel 2.
    fire(0, 8'h01, 1'b1); step();
    fire(0, 8'h02, 1'b1); fire(2, 8'h21, 1'b1); step();
    fire(0, 8'h03, 1'b0); fire(2, 8'h22, 1'b1); step();
    check("ovf0_pre", overflow, 4'b0001);
    flagi[0] = 1'b0;
    fire(2, 8'h23, 1'b0); ovf_clr = 1'b1; step();
    flagi = '0; ovf_clr = 1'b0;
    check("ovf_clr_coinc", overflow, 4'b0100);
    drain();
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;

    // Reset with a launched request and a pending event outstanding.
    fire(3, 8'h71, 1'b1); step();
    fire(3, 8'h72, 1'b1); step();
    flagi = '0;
    check("rst_mid_busy", busy, 4'b1000);
    rst = 1'b1;
    expq[3].delete();
    for (int k = 0; k < 30; k++) begin
      step();
      if (k % 6 == 5) check("rst_mid_flago", flago, 0);
    end
    rst = 1'b0;
    step();
    check("rst_mid_outs", {busy, overflow, flago}, 0);
    check("rst_mid_datao", datao, 0);
    fire(3, 8'h5A, 1'b1); step(); flagi = '0;
    drain();
    check("rst_mid_next", dlv[3], 1);

    // Randomized traffic at clk1 = clk0/3 and clk1 = 3*clk0.
    for (int r = 0; r < 2; r++) begin
      h0 = (r == 0) ? 5 : 15;
      h1 = (r == 0) ? 15 : 5;
      do_reset();
      total = 0;
      cyc = 0;
      while (total < 200 && cyc < 20000) begin
        for (int ch = 0; ch < NCH; ch++) begin
          if (total < 200 && expq[ch].size() == 0 && $urandom_range(0, 2) == 0) begin
            fire(ch, 8'($urandom), 1'b1);
            total++;
          end
        end
        step();
        flagi = '0;
        cyc++;
      end
      drain();
      check($sformatf("rnd%0d_count", r), dlv[0] + dlv[1] + dlv[2] + dlv[3], 200);
      check($sformatf("rnd%0d_ovf", r), overflow, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
